// File: rtl/byte_mem_pkg.sv
// Shared encodings, state enum and size helper for the byte-addressable data memory.
// Build option: BYTE_MEM_CLEAR_EN adds the CLEAR state (zero sweep after reset).
package byte_mem_pkg;

    localparam logic [1:0] SZ_B    = 2'd0;
    localparam logic [1:0] SZ_H    = 2'd1;
    localparam logic [1:0] SZ_W    = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [1:0] {
`ifdef BYTE_MEM_CLEAR_EN
        ST_CLEAR = 2'd3,
`endif
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    // Reserved size reports 4 bytes; it faults anyway, so the value only feeds the range check.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    size_bytes = 3'd1;
            SZ_H:    size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/byte_mem_ctrl_if.sv
// Request/response bus of the data memory: valid/ready request channel and valid/ready response channel.
interface byte_mem_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_fault;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/byte_mem_lane.sv
// Combinational lane logic: store byte enables and steering, load select/extend, fault detection.
// Latency: none. Backpressure: none (pure function of its inputs).
module byte_mem_lane
    import byte_mem_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [31:0]       rd_word,
    output logic [3:0]        wr_be,
    output logic [31:0]       wr_data,
    output logic [31:0]       ld_data,
    output logic              fault
);

    logic [31:0]       rd_shift;
    logic [ADDR_W+1:0] last_byte;
    logic              misalign;
    logic              out_of_range;

    always_comb begin
        wr_be   = 4'b0000;
        wr_data = 32'h0;
        ld_data = 32'h0;
        // Aligned accesses only reach memory, so a right shift by the byte offset lines up the lane.
        rd_shift = rd_word >> {addr[1:0], 3'b000};
        case (size)
            SZ_B: begin
                wr_be   = 4'b0001 << addr[1:0];
                wr_data = {4{wdata[7:0]}};
                ld_data = uns ? {24'h0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
            end
            SZ_H: begin
                wr_be   = 4'b0011 << addr[1:0];
                wr_data = {2{wdata[15:0]}};
                ld_data = uns ? {16'h0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
            end
            SZ_W: begin
                wr_be   = 4'b1111;
                wr_data = wdata;
                ld_data = rd_word;
            end
            default: begin
                wr_be   = 4'b0000;
                wr_data = 32'h0;
                ld_data = 32'h0;
            end
        endcase
    end

    always_comb begin
        last_byte    = {2'b00, addr} + (ADDR_W+2)'(size_bytes(size)) - (ADDR_W+2)'(1);
        out_of_range = (last_byte >= (ADDR_W+2)'(DEPTH));
        misalign     = ((size == SZ_H) && addr[0]) ||
                       ((size == SZ_W) && (addr[1:0] != 2'b00));
        fault        = (size == SZ_RSVD) || misalign || out_of_range;
    end

endmodule

// File: rtl/byte_mem_ctrl.sv
// Byte-addressable little-endian data memory with wait states; BYTE_MEM_CLEAR_EN adds a zero sweep after reset.
// Latency: WAIT_CYCLES+1 cycles from accept to rsp_valid. Backpressure: rsp_ready low holds RESP; req_ready low outside IDLE.
module byte_mem_ctrl
    import byte_mem_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset,
    byte_mem_ctrl_if.slave  bus,
    output logic            busy
);

    localparam int         WI_W      = $clog2(DEPTH / 4);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam state_e     ACC_NEXT  = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;

    state_e state_q, state_d;

    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              fault_q, fault_d;

    logic [31:0] mem_q [DEPTH/4];

    logic              accept;
    logic              commit;
    logic              wr_en;
    logic              cur_we;
    logic [1:0]        cur_size;
    logic              cur_uns;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic [WI_W-1:0]   widx;
    logic [31:0]       rd_word;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;
    logic [31:0]       ld_data;
    logic              flt;

`ifdef BYTE_MEM_CLEAR_EN
    localparam logic [WI_W-1:0] CLR_LAST = '1;
    logic [WI_W-1:0] clr_cnt_q, clr_cnt_d;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
`ifdef BYTE_MEM_CLEAR_EN
            state_q <= ST_CLEAR;
`else
            state_q <= ST_IDLE;
`endif
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
`ifdef BYTE_MEM_CLEAR_EN
            ST_CLEAR: if (clr_cnt_q == CLR_LAST) state_d = ST_IDLE;
`endif
            ST_IDLE:  if (bus.req_valid) state_d = ACC_NEXT;
            ST_WAIT:  if (wait_cnt_q == 4'd0) state_d = ST_RESP;
            ST_RESP:  if (bus.rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        bus.req_ready = (state_q == ST_IDLE);
        bus.rsp_valid = (state_q == ST_RESP);
        bus.rsp_rdata = rdata_q;
        bus.rsp_fault = fault_q;
        busy          = (state_q != ST_IDLE);
    end

    // ---------------- datapath ----------------
    // With zero wait states the commit happens on the accept edge, so the live request is used there.
    always_comb begin
        accept    = (state_q == ST_IDLE) && bus.req_valid;
        cur_we    = (state_q == ST_IDLE) ? bus.req_we       : we_q;
        cur_size  = (state_q == ST_IDLE) ? bus.req_size     : size_q;
        cur_uns   = (state_q == ST_IDLE) ? bus.req_unsigned : uns_q;
        cur_addr  = (state_q == ST_IDLE) ? bus.req_addr     : addr_q;
        cur_wdata = (state_q == ST_IDLE) ? bus.req_wdata    : wdata_q;
        widx      = cur_addr[WI_W+1:2];
        rd_word   = mem_q[widx];
        commit    = (state_d == ST_RESP) && (state_q != ST_RESP) && !reset;
        wr_en     = commit && cur_we && !flt;
    end

    byte_mem_lane #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_lane (
        .size    (cur_size),
        .uns     (cur_uns),
        .addr    (cur_addr),
        .wdata   (cur_wdata),
        .rd_word (rd_word),
        .wr_be   (wr_be),
        .wr_data (wr_data),
        .ld_data (ld_data),
        .fault   (flt)
    );

    always_comb begin
        we_d       = accept ? bus.req_we       : we_q;
        size_d     = accept ? bus.req_size     : size_q;
        uns_d      = accept ? bus.req_unsigned : uns_q;
        addr_d     = accept ? bus.req_addr     : addr_q;
        wdata_d    = accept ? bus.req_wdata    : wdata_q;
        wait_cnt_d = wait_cnt_q;
        if (accept)
            wait_cnt_d = WAIT_INIT;
        else if ((state_q == ST_WAIT) && (wait_cnt_q != 4'd0))
            wait_cnt_d = wait_cnt_q - 4'd1;
        rdata_d = rdata_q;
        fault_d = fault_q;
        if (commit) begin
            rdata_d = (flt || cur_we) ? 32'h0 : ld_data;
            fault_d = flt;
        end
`ifdef BYTE_MEM_CLEAR_EN
        clr_cnt_d = (state_q == ST_CLEAR) ? clr_cnt_q + 1'b1 : clr_cnt_q;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q       <= 1'b0;
            size_q     <= SZ_B;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            wait_cnt_q <= 4'd0;
            rdata_q    <= 32'h0;
            fault_q    <= 1'b0;
`ifdef BYTE_MEM_CLEAR_EN
            clr_cnt_q  <= '0;
`endif
        end else begin
            we_q       <= we_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wait_cnt_q <= wait_cnt_d;
            rdata_q    <= rdata_d;
            fault_q    <= fault_d;
`ifdef BYTE_MEM_CLEAR_EN
            clr_cnt_q  <= clr_cnt_d;
`endif
        end
    end

    // Storage is not reset so contents survive a reset unless the sweep clears them.
    always_ff @(posedge clk) begin
`ifdef BYTE_MEM_CLEAR_EN
        if (state_q == ST_CLEAR) begin
            mem_q[clr_cnt_q] <= 32'h0;
        end else if (wr_en) begin
            for (int k = 0; k < 4; k++)
                if (wr_be[k]) mem_q[widx][k*8 +: 8] <= wr_data[k*8 +: 8];
        end
`else
        if (wr_en) begin
            for (int k = 0; k < 4; k++)
                if (wr_be[k]) mem_q[widx][k*8 +: 8] <= wr_data[k*8 +: 8];
        end
`endif
    end

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Directed bench: dut1 is the default build (WAIT_CYCLES=1, DEPTH=4096), dut0 a small zero-wait instance (DEPTH=64).
module tb_byte_mem_ctrl;
    import byte_mem_pkg::*;

`ifdef BYTE_MEM_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy0, busy1;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    byte_mem_ctrl_if #(.ADDR_W(12)) if0 ();
    byte_mem_ctrl_if #(.ADDR_W(12)) if1 ();

    byte_mem_ctrl #(.ADDR_W(12), .DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(if0.slave), .busy(busy0));
    byte_mem_ctrl #(.ADDR_W(12), .DEPTH(4096), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1.slave), .busy(busy1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic rsp_vld(input int d);
        return (d == 0) ? if0.rsp_valid : if1.rsp_valid;
    endfunction

    task automatic drive(input int d, input logic v, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [11:0] a, input logic [31:0] wd);
        if (d == 0) begin
            if0.req_valid = v; if0.req_we = we; if0.req_size = sz;
            if0.req_unsigned = uns; if0.req_addr = a; if0.req_wdata = wd;
        end else begin
            if1.req_valid = v; if1.req_we = we; if1.req_size = sz;
            if1.req_unsigned = uns; if1.req_addr = a; if1.req_wdata = wd;
        end
    endtask

    // One complete access with rsp_ready held high; lat counts posedges from accept edge to rsp_valid.
    task automatic op(input int d, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [11:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic flt, output int lat);
        @(negedge clk);
        drive(d, 1'b1, we, sz, uns, a, wd);
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b0, SZ_B, 1'b0, 12'h0, 32'h0);
        lat = 1;
        while (!rsp_vld(d) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd  = (d == 0) ? if0.rsp_rdata : if1.rsp_rdata;
        flt = (d == 0) ? if0.rsp_fault : if1.rsp_fault;
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input int lim, output int n);
        n = 0;
        while ((busy0 || busy1) && n < lim) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    logic [31:0] rd;
    logic        flt;
    int          lat;
    int          n;

    initial begin
        drive(0, 1'b0, 1'b0, SZ_B, 1'b0, 12'h0, 32'h0);
        drive(1, 1'b0, 1'b0, SZ_B, 1'b0, 12'h0, 32'h0);
        if0.rsp_ready = 1'b1;
        if1.rsp_ready = 1'b1;
        #12;
        check("rst_req_ready", {31'h0, if1.req_ready}, {31'h0, ~CLR});
        check("rst_rsp_valid", {31'h0, if1.rsp_valid}, 32'h0);
        check("rst_rdata",     if1.rsp_rdata, 32'h0);
        check("rst_fault",     {31'h0, if1.rsp_fault}, 32'h0);
        check("rst_busy",      {31'h0, busy1}, {31'h0, CLR});

        @(negedge clk); reset = 1'b0; #1;
        n = 0;
        while (busy0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("clear_cycles_d64", n, CLR ? 32'd16 : 32'd0);
        check("req_ready_after_clear", {31'h0, if0.req_ready}, 32'h1);
        wait_idle(5000, n);
        check("both_idle", {30'h0, busy1, busy0}, 32'h0);

        // small zero-wait instance
        op(0, 1'b0, SZ_W, 1'b0, 12'h03C, 32'h0, rd, flt, lat);
        if (CLR) check("d0_cleared_load", rd, 32'h0);
        op(0, 1'b1, SZ_W, 1'b0, 12'h03C, 32'h0BADF00D, rd, flt, lat);
        check("d0_store_lat", lat, 32'd1);
        op(0, 1'b0, SZ_W, 1'b0, 12'h03C, 32'h0, rd, flt, lat);
        check("d0_load_w", rd, 32'h0BADF00D);
        check("d0_load_lat", lat, 32'd1);
        op(0, 1'b0, SZ_H, 1'b1, 12'h03E, 32'h0, rd, flt, lat);
        check("d0_half_top", {flt, rd[30:0]}, 32'h00000BAD);
        op(0, 1'b0, SZ_W, 1'b0, 12'h03E, 32'h0, rd, flt, lat);
        check("d0_word_depthm2_fault", {31'h0, flt}, 32'h1);
        op(0, 1'b0, SZ_B, 1'b0, 12'h040, 32'h0, rd, flt, lat);
        check("d0_byte_oor_fault", {31'h0, flt}, 32'h1);
        check("d0_byte_oor_rdata", rd, 32'h0);

        // word store / load and byte extension
        op(1, 1'b1, SZ_W, 1'b0, 12'h010, 32'hDEADBEEF, rd, flt, lat);
        check("st_w_rdata", rd, 32'h0);
        check("st_w_fault", {31'h0, flt}, 32'h0);
        op(1, 1'b0, SZ_W, 1'b0, 12'h010, 32'h0, rd, flt, lat);
        check("ld_w", rd, 32'hDEADBEEF);
        check("ld_w_lat", lat, 32'd2);
        op(1, 1'b0, SZ_B, 1'b0, 12'h013, 32'h0, rd, flt, lat);
        check("ld_b_s", rd, 32'hFFFFFFDE);
        op(1, 1'b0, SZ_B, 1'b1, 12'h013, 32'h0, rd, flt, lat);
        check("ld_b_u", rd, 32'h000000DE);

        // half store inside known neighbours
        op(1, 1'b1, SZ_W, 1'b0, 12'h020, 32'h44332211, rd, flt, lat);
        op(1, 1'b1, SZ_W, 1'b0, 12'h024, 32'h88776655, rd, flt, lat);
        op(1, 1'b1, SZ_H, 1'b0, 12'h022, 32'h12348001, rd, flt, lat);
        op(1, 1'b0, SZ_H, 1'b0, 12'h022, 32'h0, rd, flt, lat);
        check("ld_h_s", rd, 32'hFFFF8001);
        op(1, 1'b0, SZ_H, 1'b1, 12'h022, 32'h0, rd, flt, lat);
        check("ld_h_u", rd, 32'h00008001);
        op(1, 1'b0, SZ_B, 1'b1, 12'h020, 32'h0, rd, flt, lat);
        check("byte_20", rd, 32'h00000011);
        op(1, 1'b0, SZ_B, 1'b1, 12'h021, 32'h0, rd, flt, lat);
        check("byte_21", rd, 32'h00000022);
        op(1, 1'b0, SZ_B, 1'b0, 12'h024, 32'h0, rd, flt, lat);
        check("byte_24", rd, 32'h00000055);
        op(1, 1'b0, SZ_W, 1'b1, 12'h020, 32'h0, rd, flt, lat);
        check("word_20", rd, 32'h80012211);

        // faults
        op(1, 1'b0, SZ_W, 1'b0, 12'h006, 32'h0, rd, flt, lat);
        check("flt_w06", {flt, rd[30:0]}, 32'h80000000);
        check("flt_w06_lat", lat, 32'd2);
        op(1, 1'b1, SZ_W, 1'b0, 12'h004, 32'hCAFEF00D, rd, flt, lat);
        op(1, 1'b1, SZ_H, 1'b0, 12'h005, 32'h0000FFFF, rd, flt, lat);
        check("flt_h05", {flt, rd[30:0]}, 32'h80000000);
        op(1, 1'b0, SZ_W, 1'b0, 12'h004, 32'h0, rd, flt, lat);
        check("h05_no_write", rd, 32'hCAFEF00D);
        op(1, 1'b0, SZ_W, 1'b0, 12'hFFE, 32'h0, rd, flt, lat);
        check("flt_w_depthm2", {flt, rd[30:0]}, 32'h80000000);
        op(1, 1'b1, SZ_W, 1'b0, 12'hFFC, 32'h01020304, rd, flt, lat);
        op(1, 1'b0, SZ_B, 1'b1, 12'hFFF, 32'h0, rd, flt, lat);
        check("byte_last_ok", {flt, rd[30:0]}, 32'h00000001);
        op(1, 1'b0, SZ_B, 1'b0, 12'h010, 32'h0, rd, flt, lat);
        op(1, 1'b0, SZ_RSVD, 1'b0, 12'h010, 32'h0, rd, flt, lat);
        check("flt_size3", {flt, rd[30:0]}, 32'h80000000);

        // back-pressure
        @(negedge clk);
        if1.rsp_ready = 1'b0;
        drive(1, 1'b1, 1'b0, SZ_W, 1'b0, 12'h010, 32'h0);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, SZ_B, 1'b0, 12'h0, 32'h0);
        n = 0;
        while (!if1.rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (5) @(posedge clk);
        #1;
        check("bp_valid", {31'h0, if1.rsp_valid}, 32'h1);
        check("bp_rdata", if1.rsp_rdata, 32'hDEADBEEF);
        check("bp_fault_ready", {30'h0, if1.rsp_fault, if1.req_ready}, 32'h0);
        @(negedge clk); if1.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {30'h0, if1.rsp_valid, if1.req_ready}, 32'h1);

        // reset during a pending store
        op(1, 1'b1, SZ_W, 1'b0, 12'h040, 32'h11223344, rd, flt, lat);
        op(1, 1'b0, SZ_W, 1'b0, 12'h040, 32'h0, rd, flt, lat);
        check("pre_rst_load", rd, 32'h11223344);
        @(negedge clk);
        drive(1, 1'b1, 1'b1, SZ_W, 1'b0, 12'h040, 32'hAAAAAAAA);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, SZ_B, 1'b0, 12'h0, 32'h0);
        check("in_wait_busy", {31'h0, busy1}, 32'h1);
        reset = 1'b1; #1;
        check("mid_rst_ready_busy", {30'h0, if1.req_ready, busy1}, {30'h0, ~CLR, CLR});
        check("mid_rst_valid_fault", {30'h0, if1.rsp_valid, if1.rsp_fault}, 32'h0);
        check("mid_rst_rdata", if1.rsp_rdata, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        wait_idle(5000, n);
        check("post_rst_idle", {31'h0, busy1}, 32'h0);
        op(1, 1'b0, SZ_W, 1'b0, 12'h040, 32'h0, rd, flt, lat);
        check("post_rst_load", rd, CLR ? 32'h0 : 32'h11223344);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/byte_mem_ctrl.md
# byte_mem_ctrl

Parametrised, byte-addressable, little-endian data memory with a valid/ready request/response handshake and a configurable number of wait states. It serves byte, halfword and word loads/stores with sign or zero extension and flags misaligned or out-of-range accesses. It sits behind the MEM stage of the pipelined processor and replaces the fixed 32-bit negedge memory with a posedge, stall-capable slave.

## Interface
- `ADDR_W`, 12: request address width in bits.
- `DEPTH`, 4096: size in bytes. Must be a power of two, a multiple of 4, and ≤ 2^ADDR_W.
- `WAIT_CYCLES`, 1: extra cycles between request acceptance and response. Range 0..15.

Ports:
- `clk`  in  1: clock; all logic is posedge.
- `reset`  in  1: reset, asynchronous, active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: controller can accept a request.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: 0 = byte, 1 = half, 2 = word, 3 = reserved.
- `req_unsigned`  in  1: zero-extend loads when 1; sign-extend when 0.
- `req_addr`  in  ADDR_W: byte address.
- `req_wdata`  in  32: store data, right-aligned.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_rdata`  out  32: extended load data; 0 for stores and faults.
- `rsp_fault`  out  1: access was misaligned, out of range, or used the reserved size.
- `busy`  out  1: controller is not in IDLE.

## Operation
- States: CLEAR (present only with the macro), IDLE, WAIT, RESP.
- IDLE
  - `req_ready` = 1.
  - On `req_valid && req_ready`, latch `we`, `size`, `unsigned`, `addr` and `wdata`.
  - Go to WAIT if `WAIT_CYCLES` > 0, otherwise to RESP.
- WAIT
  - The wait counter loads `WAIT_CYCLES` − 1 at acceptance and decrements each cycle.
  - Go to RESP when the counter reaches 0.
- Entry into RESP is the single commit point:
  - A store writes its bytes.
  - A load samples memory, extends the data and registers it into `rsp_rdata`.
- RESP
  - `rsp_valid` = 1. `rsp_rdata` and `rsp_fault` are held stable until `rsp_valid && rsp_ready`, then go to IDLE.
  - `req_ready` = 0 in WAIT and RESP; no request is accepted in the same cycle as a response handshake.
- Fault conditions:
  - size 3;
  - half at an odd address;
  - word with `addr[1:0]` ≠ 0;
  - `addr + bytes − 1` ≥ `DEPTH`.
- On a fault: no memory write, `rsp_rdata` = 0, `rsp_fault` = 1, and a response is still produced after the same latency.
- Stores, little-endian:
  - byte writes `wdata[7:0]` to `addr`;
  - half writes `[7:0]` to `addr` and `[15:8]` to `addr+1`;
  - word writes all four bytes, `addr` to `addr+3`.
- Loads:
  - byte: extend bit 7;
  - half: extend bit 15;
  - word: `req_unsigned` is ignored.
- Request inputs are don't-care outside the accept cycle.

## Timing
- Reset values: `req_ready` = 1 (0 with the macro), `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_fault` = 0, `busy` = 0 (1 with the macro).
- Latency: `rsp_valid` rises at the (`WAIT_CYCLES` + 1)th posedge after the accept edge.
- Minimum request period is `WAIT_CYCLES` + 2 cycles when `rsp_ready` is held at 1.
- Back-pressure: `rsp_ready` = 0 extends RESP indefinitely with no change to the outputs.
- Reset mid-operation:
  - the pending access is dropped, and a store that has not yet entered RESP is not written;
  - memory contents are preserved unless the macro is defined.
- Same-address read after write: a load accepted after a store's response returns the new data.

## Configuration
- `BYTE_MEM_CLEAR_EN`
  - Defined: reset enters CLEAR. A sweep writes one zero word per cycle from address 0 to `DEPTH` − 4, taking `DEPTH`/4 cycles, with `busy` = 1 and `req_ready` = 0; then the controller enters IDLE. Reset asserted during the sweep restarts it at 0.
  - Undefined: there is no CLEAR state, reset goes straight to IDLE, and memory contents are uninitialised.

## Structure
- `byte_mem_pkg` holds:
  - the size encodings `SZ_B`, `SZ_H`, `SZ_W`, `SZ_RSVD`;
  - the state enum;
  - the function returning byte count from size.
- Sub-module `byte_mem_lane` (combinational) provides:
  - write byte-lane enables and steered data from size and `addr[1:0]`;
  - load byte selection and sign/zero extension;
  - the fault computation.
- The top level holds the FSM, the wait counter, the clear counter and the byte array.

## Test plan
- `WAIT_CYCLES` = 1: store word 0xDEADBEEF at 0x10, then load word 0x10 → `rdata` 0xDEADBEEF with `rsp_valid` 2 cycles after accept; byte load 0x13 signed → 0xFFFFFFDE; unsigned → 0x000000DE.
- Store half 0x8001 at 0x22, then load half 0x22 signed → 0xFFFF8001; unsigned → 0x00008001; bytes 0x20–0x21 and 0x24 unchanged.
- Misaligned and out-of-range faults, each giving `rsp_fault` = 1 and `rdata` 0:
  - word load at 0x06;
  - half store at 0x05 (memory unchanged);
  - word at `DEPTH` − 2;
  - size 3.
- Back-pressure: hold `rsp_ready` = 0 for 5 cycles → `rsp_valid`, `rdata` and `fault` stable, `req_ready` = 0; release → IDLE next cycle.
- Reset asserted during WAIT of a store to 0x40 → all outputs at reset values immediately; a later load of 0x40 returns the old value (macro undefined) or 0 (macro defined).
- Macro defined, `DEPTH` = 64: `busy` = 1 for exactly 16 cycles after reset deasserts, then `req_ready` = 1; any load returns 0. `WAIT_CYCLES` = 0 variant: response exactly 1 cycle after accept.
